acc_len_sync_ctrl: RTL and testbench

- Accumulation controller in the `user_clk` domain, directly downstream of the software-written accumulation-length register.
- Consumes the 32-bit accumulation length and the FFT spectrum sync/valid stream.
- Counts samples and spectra, and emits a one-cycle `new_acc` marker to the vector accumulator at the start of every accumulation.
- Exposes a completed-accumulation counter and status flags for readback registers.

---
 rtl/acc_len_sync_ctrl_if.sv | 26 ++
 rtl/acc_len_sync_ctrl.sv | 152 +++++++++++++++
 tb/tb_acc_len_sync_ctrl.sv | 515 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_len_sync_ctrl_if.sv
// Accumulation-length / sync control bundle.
// Signals: acc_len, arm, sync_in, en (to controller);
//          new_acc, acc_cnt, armed, running, sync_err (from controller).
interface acc_len_sync_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      acc_len;
    logic             arm;
    logic             sync_in;
    logic             en;
    logic             new_acc;
    logic [CNT_W-1:0] acc_cnt;
    logic             armed;
    logic             running;
    logic             sync_err;

    modport master (
        output acc_len, arm, sync_in, en,
        input  new_acc, acc_cnt, armed, running, sync_err
    );

    modport slave (
        input  acc_len, arm, sync_in, en,
        output new_acc, acc_cnt, armed, running, sync_err
    );
endinterface

// File: rtl/acc_len_sync_ctrl.sv
// Accumulation controller: counts samples/spectra, emits new_acc
// at the start of each accumulation and tracks completed accumulations.
// Ports: user_clk, user_rst (sync, active-high), bus (slave modport):
//   acc_len, arm, sync_in, en in; new_acc, acc_cnt, armed, running,
//   sync_err out.
module acc_len_sync_ctrl #(
    parameter int SPEC_LEN_BITS = 10,
    parameter int CNT_W         = 32
) (
    input  logic               user_clk,
    input  logic               user_rst,
    acc_len_sync_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SPEC_LEN_BITS-1:0] samp_cnt;
    logic [31:0]              spec_cnt;
    logic [31:0]              len_q;
    logic [CNT_W-1:0]         acc_cnt;
    logic                     new_acc;
    logic                     sync_err;

    logic sync_q;
    logic samp_zero;
    logic samp_wrap;
    logic spec_last;

    logic start_acc;
    logic realign;
    logic resync;
    logic step;
    logic acc_done;
    logic enter_armed;

    assign sync_q    = bus.sync_in & bus.en;
    assign samp_zero = (samp_cnt == '0);
    assign samp_wrap = &samp_cnt;
    assign spec_last = (spec_cnt == len_q - 32'd1);

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // realign: this cycle is forced to be sample 0 (first sync after
    // arming, or a misplaced sync in RUN).  step: normal sample advance.
    always_comb begin
        state_nxt   = state;
        start_acc   = 1'b0;
        realign     = 1'b0;
        resync      = 1'b0;
        step        = 1'b0;
        acc_done    = 1'b0;
        enter_armed = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.arm) begin
                    state_nxt   = ARMED;
                    enter_armed = 1'b1;
                end
            end
            ARMED: begin
                if (bus.arm) begin
                    enter_armed = 1'b1;
                end else if (sync_q) begin
                    state_nxt = RUN;
                    start_acc = 1'b1;
                    realign   = 1'b1;
                end
            end
            RUN: begin
                if (bus.arm) begin
                    state_nxt   = ARMED;
                    enter_armed = 1'b1;
                end else if (bus.en) begin
                    if (sync_q && !samp_zero) begin
                        resync    = 1'b1;
                        realign   = 1'b1;
                        start_acc = 1'b1;
                    end else begin
                        step      = 1'b1;
                        start_acc = samp_zero && (spec_cnt == 32'd0);
                        acc_done  = samp_wrap && spec_last;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            samp_cnt <= '0;
            spec_cnt <= '0;
            len_q    <= '0;
            acc_cnt  <= '0;
            new_acc  <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            // A resync right after a start would give back-to-back
            // markers; the second one is dropped so new_acc stays a
            // single-cycle pulse.
            new_acc <= start_acc & ~new_acc;

            if (start_acc) begin
                len_q <= (bus.acc_len == 32'd0) ? 32'd1 : bus.acc_len;
            end

            if (enter_armed) begin
                samp_cnt <= '0;
                spec_cnt <= '0;
                acc_cnt  <= '0;
                sync_err <= 1'b0;
            end else if (realign) begin
                // This cycle is sample 0, so the next one is sample 1.
                samp_cnt <= SPEC_LEN_BITS'(1);
                spec_cnt <= '0;
                if (resync) begin
                    sync_err <= 1'b1;
                end
            end else if (step) begin
                samp_cnt <= samp_cnt + SPEC_LEN_BITS'(1);
                if (samp_wrap) begin
                    spec_cnt <= spec_last ? 32'd0 : spec_cnt + 32'd1;
                end
                if (acc_done) begin
                    acc_cnt <= acc_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.new_acc  = new_acc;
    assign bus.acc_cnt  = acc_cnt;
    assign bus.armed    = (state == ARMED);
    assign bus.running  = (state == RUN);
    assign bus.sync_err = sync_err;

endmodule

// File: tb/tb_acc_len_sync_ctrl.sv
// Testbench for acc_len_sync_ctrl with 4-sample spectra.
// Expected new_acc cycles are queued per scenario and matched to observed.
module tb_acc_len_sync_ctrl;

    localparam int SLB = 2;
    localparam int CW  = 32;

    logic user_clk = 1'b0;
    logic user_rst = 1'b1;

    acc_len_sync_ctrl_if #(.CNT_W(CW)) bus ();

    acc_len_sync_ctrl #(
        .SPEC_LEN_BITS(SLB),
        .CNT_W        (CW)
    ) dut (
        .user_clk(user_clk),
        .user_rst(user_rst),
        .bus     (bus)
    );

    always #5 user_clk = ~user_clk;

    int cyc = 0;
    int exp_q[$];
    int obs_q[$];
    int nvec = 0;
    int nerr = 0;

    always @(posedge user_clk) cyc <= cyc + 1;

    always @(negedge user_clk)
        if (bus.new_acc === 1'b1) obs_q.push_back(cyc);

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic do_reset();
        user_rst    = 1'b1;
        bus.arm     = 1'b0;
        bus.sync_in = 1'b0;
        bus.en      = 1'b1;
        tick();
        tick();
        user_rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic arm_then_sync(input logic [31:0] len, output int e);
        bus.acc_len = len;
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        tick();
        bus.sync_in = 1'b1;
        tick();
        bus.sync_in = 1'b0;
        e = cyc;
    endtask

    task automatic test_reset();
        user_rst    = 1'b1;
        bus.arm     = 1'b1;
        bus.sync_in = 1'b1;
        bus.en      = 1'b1;
        bus.acc_len = 32'd3;
        tick();
        nvec++;
        if (bus.new_acc !== 1'b0) begin
            nerr++;
            $display("FAIL reset_new_acc got %b want 0", bus.new_acc);
        end
        nvec++;
        if (bus.acc_cnt !== '0) begin
            nerr++;
            $display("FAIL reset_acc_cnt got %0d want 0", bus.acc_cnt);
        end
        nvec++;
        if (bus.armed !== 1'b0) begin
            nerr++;
            $display("FAIL reset_armed got %b want 0", bus.armed);
        end
        nvec++;
        if (bus.running !== 1'b0) begin
            nerr++;
            $display("FAIL reset_running got %b want 0", bus.running);
        end
        nvec++;
        if (bus.sync_err !== 1'b0) begin
            nerr++;
            $display("FAIL reset_sync_err got %b want 0", bus.sync_err);
        end
        bus.arm     = 1'b0;
        bus.sync_in = 1'b0;
    endtask

    task automatic test_basic();
        int e;
        int o;
        int x;
        do_reset();
        bus.acc_len = 32'd3;
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        nvec++;
        if (bus.armed !== 1'b1 || bus.running !== 1'b0) begin
            nerr++;
            $display("FAIL basic_armed armed=%b running=%b want 1/0",
                     bus.armed, bus.running);
        end
        repeat (3) tick();
        bus.sync_in = 1'b1;
        tick();
        bus.sync_in = 1'b0;
        e = cyc;
        exp_q.push_back(e);
        exp_q.push_back(e + 12);
        exp_q.push_back(e + 24);
        nvec++;
        if (bus.running !== 1'b1 || bus.armed !== 1'b0) begin
            nerr++;
            $display("FAIL basic_running running=%b armed=%b want 1/0",
                     bus.running, bus.armed);
        end
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 10) begin
                nvec++;
                if (bus.acc_cnt !== 32'd0) begin
                    nerr++;
                    $display("FAIL basic_cnt10 got %0d want 0", bus.acc_cnt);
                end
            end
            if (i == 11) begin
                nvec++;
                if (bus.acc_cnt !== 32'd1) begin
                    nerr++;
                    $display("FAIL basic_cnt11 got %0d want 1", bus.acc_cnt);
                end
            end
            if (i == 23) begin
                nvec++;
                if (bus.acc_cnt !== 32'd2) begin
                    nerr++;
                    $display("FAIL basic_cnt23 got %0d want 2", bus.acc_cnt);
                end
            end
        end
        @(negedge user_clk);
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL basic_npulse got %0d want %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            x = exp_q.pop_front();
            o = obs_q.pop_front();
            nvec++;
            if (o != x) begin
                nerr++;
                $display("FAIL basic_pulse at cycle %0d want %0d", o, x);
            end
        end
    endtask

    task automatic test_len_zero();
        int e;
        int o;
        int x;
        do_reset();
        arm_then_sync(32'd0, e);
        for (int k = 0; k <= 12; k += 4) exp_q.push_back(e + k);
        repeat (14) tick();
        nvec++;
        if (bus.acc_cnt !== 32'd3) begin
            nerr++;
            $display("FAIL len0_cnt got %0d want 3", bus.acc_cnt);
        end
        @(negedge user_clk);
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL len0_npulse got %0d want %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            x = exp_q.pop_front();
            o = obs_q.pop_front();
            nvec++;
            if (o != x) begin
                nerr++;
                $display("FAIL len0_pulse at cycle %0d want %0d", o, x);
            end
        end
    endtask

    task automatic test_len_change();
        int e;
        int o;
        int x;
        do_reset();
        arm_then_sync(32'd3, e);
        exp_q.push_back(e);
        exp_q.push_back(e + 12);
        exp_q.push_back(e + 20);
        exp_q.push_back(e + 28);
        for (int i = 1; i <= 30; i++) begin
            if (i == 5) bus.acc_len = 32'd2;
            tick();
        end
        nvec++;
        if (bus.acc_cnt !== 32'd3) begin
            nerr++;
            $display("FAIL lenchg_cnt got %0d want 3", bus.acc_cnt);
        end
        @(negedge user_clk);
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL lenchg_npulse got %0d want %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            x = exp_q.pop_front();
            o = obs_q.pop_front();
            nvec++;
            if (o != x) begin
                nerr++;
                $display("FAIL lenchg_pulse at cycle %0d want %0d", o, x);
            end
        end
    endtask

    task automatic test_en_toggle();
        int e;
        int o;
        int x;
        do_reset();
        arm_then_sync(32'd1, e);
        exp_q.push_back(e);
        exp_q.push_back(e + 8);
        exp_q.push_back(e + 16);
        for (int i = 1; i <= 20; i++) begin
            bus.en = (i % 2 == 0);
            tick();
            if (i == 5) begin
                nvec++;
                if (bus.acc_cnt !== 32'd0) begin
                    nerr++;
                    $display("FAIL en_cnt5 got %0d want 0", bus.acc_cnt);
                end
            end
            if (i == 7) begin
                nvec++;
                if (bus.acc_cnt !== 32'd1) begin
                    nerr++;
                    $display("FAIL en_cnt7 got %0d want 1", bus.acc_cnt);
                end
            end
        end
        bus.en = 1'b1;
        nvec++;
        if (bus.acc_cnt !== 32'd2) begin
            nerr++;
            $display("FAIL en_cnt20 got %0d want 2", bus.acc_cnt);
        end
        @(negedge user_clk);
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL en_npulse got %0d want %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            x = exp_q.pop_front();
            o = obs_q.pop_front();
            nvec++;
            if (o != x) begin
                nerr++;
                $display("FAIL en_pulse at cycle %0d want %0d", o, x);
            end
        end
    endtask

    task automatic test_sync_err();
        int e;
        int o;
        int x;
        do_reset();
        arm_then_sync(32'd3, e);
        exp_q.push_back(e);
        exp_q.push_back(e + 2);
        exp_q.push_back(e + 14);
        exp_q.push_back(e + 26);
        for (int i = 1; i <= 28; i++) begin
            bus.sync_in = (i == 2);
            tick();
            if (i == 1) begin
                nvec++;
                if (bus.sync_err !== 1'b0) begin
                    nerr++;
                    $display("FAIL serr_pre got %b want 0", bus.sync_err);
                end
            end
            if (i == 2) begin
                nvec++;
                if (bus.sync_err !== 1'b1) begin
                    nerr++;
                    $display("FAIL serr_set got %b want 1", bus.sync_err);
                end
            end
            if (i == 12) begin
                nvec++;
                if (bus.acc_cnt !== 32'd0) begin
                    nerr++;
                    $display("FAIL serr_cnt12 got %0d want 0", bus.acc_cnt);
                end
            end
        end
        bus.sync_in = 1'b0;
        nvec++;
        if (bus.sync_err !== 1'b1 || bus.acc_cnt !== 32'd2) begin
            nerr++;
            $display("FAIL serr_end sync_err=%b acc_cnt=%0d want 1/2",
                     bus.sync_err, bus.acc_cnt);
        end
        @(negedge user_clk);
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL serr_npulse got %0d want %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            x = exp_q.pop_front();
            o = obs_q.pop_front();
            nvec++;
            if (o != x) begin
                nerr++;
                $display("FAIL serr_pulse at cycle %0d want %0d", o, x);
            end
        end
    endtask

    task automatic test_arm_sync_idle();
        int e;
        int o;
        int x;
        do_reset();
        bus.acc_len = 32'd1;
        bus.arm     = 1'b1;
        bus.sync_in = 1'b1;
        tick();
        bus.arm = 1'b0;
        nvec++;
        if (bus.armed !== 1'b1 || bus.running !== 1'b0) begin
            nerr++;
            $display("FAIL armsync armed=%b running=%b want 1/0",
                     bus.armed, bus.running);
        end
        bus.en = 1'b0;
        tick();
        nvec++;
        if (bus.armed !== 1'b1 || bus.running !== 1'b0) begin
            nerr++;
            $display("FAIL sync_no_en armed=%b running=%b want 1/0",
                     bus.armed, bus.running);
        end
        bus.en = 1'b1;
        tick();
        bus.sync_in = 1'b0;
        e = cyc;
        exp_q.push_back(e);
        nvec++;
        if (bus.running !== 1'b1) begin
            nerr++;
            $display("FAIL armsync_run got %b want 1", bus.running);
        end
        tick();
        @(negedge user_clk);
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL armsync_npulse got %0d want %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            x = exp_q.pop_front();
            o = obs_q.pop_front();
            nvec++;
            if (o != x) begin
                nerr++;
                $display("FAIL armsync_pulse at cycle %0d want %0d", o, x);
            end
        end
    endtask

    task automatic test_arm_in_run();
        int e;
        int o;
        int x;
        do_reset();
        arm_then_sync(32'd1, e);
        exp_q.push_back(e);
        exp_q.push_back(e + 4);
        exp_q.push_back(e + 6);
        for (int i = 1; i <= 6; i++) begin
            bus.sync_in = (i == 6);
            tick();
        end
        bus.sync_in = 1'b0;
        nvec++;
        if (bus.acc_cnt !== 32'd1 || bus.sync_err !== 1'b1) begin
            nerr++;
            $display("FAIL armrun_pre acc_cnt=%0d sync_err=%b want 1/1",
                     bus.acc_cnt, bus.sync_err);
        end
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        nvec++;
        if (bus.armed !== 1'b1 || bus.running !== 1'b0 ||
            bus.acc_cnt !== 32'd0 || bus.sync_err !== 1'b0) begin
            nerr++;
            $display("FAIL armrun armed=%b running=%b cnt=%0d err=%b want 1/0/0/0",
                     bus.armed, bus.running, bus.acc_cnt, bus.sync_err);
        end
        repeat (5) tick();
        @(negedge user_clk);
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL armrun_npulse got %0d want %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            x = exp_q.pop_front();
            o = obs_q.pop_front();
            nvec++;
            if (o != x) begin
                nerr++;
                $display("FAIL armrun_pulse at cycle %0d want %0d", o, x);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int e;
        int o;
        int x;
        do_reset();
        arm_then_sync(32'd1, e);
        exp_q.push_back(e);
        repeat (3) tick();
        nvec++;
        if (bus.running !== 1'b1 || bus.acc_cnt !== 32'd1) begin
            nerr++;
            $display("FAIL rstrun_pre running=%b cnt=%0d want 1/1",
                     bus.running, bus.acc_cnt);
        end
        user_rst = 1'b1;
        tick();
        nvec++;
        if (bus.new_acc !== 1'b0 || bus.acc_cnt !== 32'd0 ||
            bus.armed !== 1'b0 || bus.running !== 1'b0 ||
            bus.sync_err !== 1'b0) begin
            nerr++;
            $display("FAIL rstrun new=%b cnt=%0d arm=%b run=%b err=%b want all 0",
                     bus.new_acc, bus.acc_cnt, bus.armed, bus.running,
                     bus.sync_err);
        end
        user_rst = 1'b0;
        tick();
        @(negedge user_clk);
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL rstrun_npulse got %0d want %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            x = exp_q.pop_front();
            o = obs_q.pop_front();
            nvec++;
            if (o != x) begin
                nerr++;
                $display("FAIL rstrun_pulse at cycle %0d want %0d", o, x);
            end
        end
    endtask

    initial begin
        bus.acc_len = 32'd0;
        bus.arm     = 1'b0;
        bus.sync_in = 1'b0;
        bus.en      = 1'b1;
        test_reset();
        test_basic();
        test_len_zero();
        test_len_change();
        test_en_toggle();
        test_sync_err();
        test_arm_sync_idle();
        test_arm_in_run();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
